apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB4 completer that fronts a word-organised register memory with slave-driven PREADY wait states, PSLVERR on out-of-range addresses, and optional byte-lane write strobes. It is the next-generation memory slave for the APB test environment: it sits directly on a requester/bridge APB port and is the DUT target for the driver/monitor/scoreboard bench.

## Interface
- DATA_WIDTH, 32, data bus width in bits; multiple of 8, range 8..64.
- ADDR_WIDTH, 8, byte-address width of PADDR.
- MEM_DEPTH, 32, number of DATA_WIDTH-bit words; must satisfy MEM_DEPTH * DATA_WIDTH/8 <= 2^ADDR_WIDTH.
- WAIT_CYCLES, 2, PREADY-low cycles inserted in every access phase; range 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSELx  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables. Present only with APB_SLAVE_PSTRB_EN.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PREADY  out  1  transfer-complete indicator; registered.
- PSLVERR  out  1  error response; registered, meaningful only while PREADY=1.

## Operation
- Word index = PADDR >> log2(DATA_WIDTH/8). The low byte-offset bits are ignored, with no alignment error.
- Setup detect: PSELx=1 and PENABLE=0 while in IDLE.
  - Latches PWRITE, word index, PWDATA and PSTRB.
  - Sets err = (index >= MEM_DEPTH).
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE → ACCESS on setup detect when WAIT_CYCLES=0.
  - IDLE → WAIT on setup detect when WAIT_CYCLES>0; loads cnt=WAIT_CYCLES.
  - WAIT: cnt decrements every cycle. Moves to ACCESS on the cycle that cnt==1.
  - WAIT → IDLE (abort) if PSELx=0 or PENABLE=0. No memory update and no error are produced.
  - ACCESS → IDLE unconditionally after one cycle.
- Outputs per state:
  - IDLE and WAIT: PREADY=0 and PSLVERR=0.
  - ACCESS: PREADY=1 and PSLVERR=err.
- Write: memory is updated on the edge that leaves ACCESS, only when err=0 and PSELx=PENABLE=1. Lanes follow PSTRB (see Configuration).
- Read: PRDATA is loaded on entry to ACCESS. It carries memory[index] when err=0 and 0 when err=1. PRDATA holds its value outside read completions.
- Write data and address are the values latched at setup. Changes on the bus during WAIT are ignored.
- Back-to-back transfers: the cycle after ACCESS is IDLE, and that IDLE cycle may itself be the next setup cycle. No dead cycle is needed.
- Reset values: state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, cnt=0, all memory words=0.
- Reset mid-transfer: the transfer is dropped with no write, and all outputs take their reset values on the next edge.

## Timing
- Setup in cycle T, PENABLE=1 from T+1 onward: PREADY=1 in cycle T+1+WAIT_CYCLES. The transfer completes at the end of that cycle.
- Total transfer length is 2+WAIT_CYCLES cycles.
- Minimum: WAIT_CYCLES=0 gives 2 cycles per transfer, and sustained throughput is one transfer per 2 cycles.
- PREADY is high for exactly one cycle per completed transfer.
- PRDATA and PSLVERR are valid in the same cycle as PREADY=1.
- A read issued after a write to the same address returns the new data, because the write commits before the next setup.

## Configuration
- Macro: APB_SLAVE_PSTRB_EN.
- Defined:
  - The PSTRB port exists.
  - A write updates only the byte lanes whose PSTRB bit is 1.
  - PSTRB=0 completes normally with no change to memory.
  - PSTRB is ignored on reads.
- Undefined:
  - There is no PSTRB port.
  - Every write updates all lanes.

## Test plan
- Reset then idle: assert PRESET for 2 cycles → PREADY=0, PSLVERR=0, PRDATA=0. Read of 0x04 returns 0x00000000.
- Write/read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x08 → PREADY rises exactly 3 cycles after setup, PSLVERR=0.
  - Read 0x08 → PRDATA=0xDEADBEEF with PREADY.
- Out of range: write 0x12345678 to 0x80 → PSLVERR=1 with PREADY. A following read of 0x80 → PSLVERR=1 and PRDATA=0. Word 0 is unchanged.
- Strobes (macro on): word 0x10 holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 → read returns 0x11BB33DD. With the macro off, the same write → 0xAABBCCDD.
- Abort and reset:
  - Drop PSELx in WAIT → FSM returns to IDLE, no PREADY pulse, memory unchanged.
  - Assert PRESET during WAIT of a write → write is dropped and outputs reset.
- Back-to-back with WAIT_CYCLES=0: 4 consecutive writes to 0x00..0x0C followed by 4 reads → PREADY on every 2nd cycle, and the data read back matches the data written.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB4 requester/completer signal bundle for apb_mem_slave.
// PSTRB exists only when APB_SLAVE_PSTRB_EN is defined.
interface apb_mem_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                    PSELx;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
   logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

`ifdef APB_SLAVE_PSTRB_EN
   modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                   input  PRDATA, PREADY, PSLVERR);
   modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
                   output PRDATA, PREADY, PSLVERR);
`else
   modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                   input  PRDATA, PREADY, PSLVERR);
   modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                   output PRDATA, PREADY, PSLVERR);
`endif
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 completer over a word memory: PREADY after WAIT_CYCLES wait states, PSLVERR past MEM_DEPTH, no backpressure upstream.
// Define APB_SLAVE_PSTRB_EN for per-byte write strobes; otherwise every write stores the full word.
module apb_mem_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_DEPTH   = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           PCLK,
   input  logic           PRESET,
   apb_mem_slave_if.slave bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int AW1    = ADDR_WIDTH + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;

   logic [1:0]            state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  wr_q, err_q;
   logic [MIDX_W-1:0]     idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
`ifdef APB_SLAVE_PSTRB_EN
   logic [STRB_W-1:0]     strb_q;
`endif
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  setup, enter_access, commit;
   logic [ADDR_WIDTH-1:0] bus_idx;
   logic [MIDX_W-1:0]     acc_idx;
   logic                  bus_err, acc_wr, acc_err;
   logic [DATA_WIDTH-1:0] rd_word;

   assign setup   = (state == S_IDLE) && bus.PSELx && !bus.PENABLE;
   assign bus_idx = bus.PADDR >> OFF_W;
   assign bus_err = {1'b0, bus_idx} >= AW1'(MEM_DEPTH);

   // With zero wait states ACCESS is entered on the setup edge itself, before the latches are loaded.
   assign acc_wr  = setup ? bus.PWRITE : wr_q;
   assign acc_err = setup ? bus_err : err_q;
   assign acc_idx = setup ? bus_idx[MIDX_W-1:0] : idx_q;
   assign rd_word = mem[acc_idx];

   assign commit  = (state == S_ACCESS) && wr_q && !err_q && bus.PSELx && bus.PENABLE;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      enter_access = 1'b0;
      case (state)
         S_IDLE: begin
            if (setup) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt    = S_ACCESS;
                  enter_access = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            if (!bus.PSELx || !bus.PENABLE) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_nxt    = S_ACCESS;
                  enter_access = 1'b1;
               end
            end
         end
         S_ACCESS: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
`ifdef APB_SLAVE_PSTRB_EN
         strb_q      <= '0;
`endif
         bus.PREADY  <= 1'b0;
         bus.PSLVERR <= 1'b0;
         bus.PRDATA  <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (setup) begin
            wr_q    <= bus.PWRITE;
            err_q   <= bus_err;
            idx_q   <= bus_idx[MIDX_W-1:0];
            wdata_q <= bus.PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q  <= bus.PSTRB;
`endif
         end
         bus.PREADY  <= enter_access;
         bus.PSLVERR <= enter_access && acc_err;
         if (enter_access && !acc_wr)
            bus.PRDATA <= acc_err ? '0 : rd_word;
         if (commit) begin
`ifdef APB_SLAVE_PSTRB_EN
            for (int b = 0; b < STRB_W; b++)
               if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
`else
            mem[idx_q] <= wdata_q;
`endif
         end
      end
   end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: directed vector table, abort/reset sequences, random traffic against a word-array model,
// and a zero-wait back-to-back run on a second instance.
module tb_apb_mem_slave;
   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 32;
   localparam int WAITC = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   apb_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAITC))
      dut0 (.PCLK(clk), .PRESET(rst), .bus(bus0));
   apb_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0))
      dut1 (.PCLK(clk), .PRESET(rst), .bus(bus1));

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    strb;
      logic [DW-1:0] rdata;
      logic          err;
   } vec_t;

   vec_t          vtab [15];
   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] model_rd;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
      end
   endtask

   task automatic idle0;
      bus0.PSELx   = 1'b0;
      bus0.PENABLE = 1'b0;
      bus0.PWRITE  = 1'b0;
      bus0.PADDR   = '0;
      bus0.PWDATA  = '0;
`ifdef APB_SLAVE_PSTRB_EN
      bus0.PSTRB   = '0;
`endif
   endtask

   task automatic idle1;
      bus1.PSELx   = 1'b0;
      bus1.PENABLE = 1'b0;
      bus1.PWRITE  = 1'b0;
      bus1.PADDR   = '0;
      bus1.PWDATA  = '0;
`ifdef APB_SLAVE_PSTRB_EN
      bus1.PSTRB   = '1;
`endif
   endtask

   // One complete transfer on bus0; address/data are scrambled after setup since only setup values count.
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [3:0] strb, output logic [DW-1:0] rdata, output logic err,
                       output int lat);
      @(posedge clk); #1;
      bus0.PSELx   = 1'b1;
      bus0.PENABLE = 1'b0;
      bus0.PWRITE  = wr;
      bus0.PADDR   = addr;
      bus0.PWDATA  = wdata;
`ifdef APB_SLAVE_PSTRB_EN
      bus0.PSTRB   = strb;
`else
      if (strb === 4'hx) bus0.PWDATA = wdata;
`endif
      @(posedge clk); #1;
      bus0.PENABLE = 1'b1;
      bus0.PADDR   = AW'($urandom);
      bus0.PWDATA  = $urandom;
      lat   = 0;
      rdata = '0;
      err   = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus0.PREADY) begin
            lat   = k;
            rdata = bus0.PRDATA;
            err   = bus0.PSLVERR;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      idle0();
      @(negedge clk);
      check("pready_one_cycle", {31'd0, bus0.PREADY}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            lat;
      int            hits;
      logic [DW-1:0] d [4];

      vtab[0]  = '{1'b0, 8'h04, 32'h0,        4'hF, 32'h00000000, 1'b0};
      vtab[1]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
      vtab[2]  = '{1'b0, 8'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vtab[3]  = '{1'b1, 8'h80, 32'h12345678, 4'hF, 32'hDEADBEEF, 1'b1};
      vtab[4]  = '{1'b0, 8'h80, 32'h0,        4'hF, 32'h00000000, 1'b1};
      vtab[5]  = '{1'b0, 8'h00, 32'h0,        4'hF, 32'h00000000, 1'b0};
      vtab[6]  = '{1'b1, 8'h10, 32'h11223344, 4'hF, 32'h00000000, 1'b0};
      vtab[7]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0};
`ifdef APB_SLAVE_PSTRB_EN
      vtab[8]  = '{1'b0, 8'h10, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
`else
      vtab[8]  = '{1'b0, 8'h10, 32'h0,        4'hF, 32'hAABBCCDD, 1'b0};
`endif
      vtab[9]  = '{1'b0, 8'h0B, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vtab[10] = '{1'b1, 8'h7C, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 1'b0};
      vtab[11] = '{1'b0, 8'h7E, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
      vtab[12] = '{1'b0, 8'hFF, 32'h0,        4'hF, 32'h00000000, 1'b1};
      vtab[13] = '{1'b1, 8'h20, 32'h55AA55AA, 4'h0, 32'h00000000, 1'b0};
`ifdef APB_SLAVE_PSTRB_EN
      vtab[14] = '{1'b0, 8'h20, 32'h0,        4'hF, 32'h00000000, 1'b0};
`else
      vtab[14] = '{1'b0, 8'h20, 32'h0,        4'hF, 32'h55AA55AA, 1'b0};
`endif

      // Reset for two cycles, then idle outputs
      rst = 1'b1;
      idle0();
      idle1();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_pready",  {31'd0, bus0.PREADY},  32'd0);
      check("reset_pslverr", {31'd0, bus0.PSLVERR}, 32'd0);
      check("reset_prdata",  bus0.PRDATA,           32'd0);

      foreach (vtab[i]) begin
         xfer(vtab[i].wr, vtab[i].addr, vtab[i].wdata, vtab[i].strb, rd, er, lat);
         check($sformatf("vec%0d_latency", i), DW'(lat), DW'(WAITC + 1));
         check($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vtab[i].err});
         check($sformatf("vec%0d_prdata", i), rd, vtab[i].rdata);
      end

      // Abort: drop PSELx/PENABLE while waiting; no PREADY, word 2 keeps its value
      @(posedge clk); #1;
      bus0.PSELx = 1'b1; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b1;
      bus0.PADDR = 8'h08; bus0.PWDATA = 32'h55555555;
`ifdef APB_SLAVE_PSTRB_EN
      bus0.PSTRB = 4'hF;
`endif
      @(posedge clk); #1;
      bus0.PENABLE = 1'b1;
      @(posedge clk); #1;
      idle0();
      hits = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus0.PREADY) hits++;
      end
      check("abort_no_pready", DW'(hits), 32'd0);
      xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er, lat);
      check("abort_mem_kept", rd, 32'hDEADBEEF);

      // Reset during the wait phase of a write
      @(posedge clk); #1;
      bus0.PSELx = 1'b1; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b1;
      bus0.PADDR = 8'h08; bus0.PWDATA = 32'h77777777;
      @(posedge clk); #1;
      bus0.PENABLE = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle0();
      @(negedge clk);
      check("midreset_pready",  {31'd0, bus0.PREADY},  32'd0);
      check("midreset_pslverr", {31'd0, bus0.PSLVERR}, 32'd0);
      check("midreset_prdata",  bus0.PRDATA,           32'd0);
      hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus0.PREADY) hits++;
      end
      check("midreset_no_pready", DW'(hits), 32'd0);
      xfer(1'b0, 8'h08, 32'h0, 4'hF, rd, er, lat);
      check("midreset_write_dropped", rd, 32'h0);

      // Random traffic against the word-array model (memory is all zero after the reset above)
      foreach (model_mem[i]) model_mem[i] = '0;
      model_rd = '0;
      for (int n = 0; n < 300; n++) begin
         logic          wr;
         logic [AW-1:0] addr;
         logic [DW-1:0] wdata;
         logic [3:0]    strb;
         logic          exp_err;
         int            idx;
         wr    = 1'($urandom);
         addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(128, 255)) : AW'($urandom_range(0, 127));
         wdata = $urandom;
         strb  = 4'($urandom);
         idx   = int'(addr) / 4;
         exp_err = (idx >= DEPTH);
         xfer(wr, addr, wdata, strb, rd, er, lat);
         if (!wr) model_rd = exp_err ? '0 : model_mem[idx];
         else if (!exp_err) begin
`ifdef APB_SLAVE_PSTRB_EN
            for (int b = 0; b < 4; b++)
               if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
`else
            model_mem[idx] = wdata;
`endif
         end
         check("rand_latency", DW'(lat), DW'(WAITC + 1));
         check("rand_pslverr", {31'd0, er}, {31'd0, exp_err});
         check("rand_prdata", rd, model_rd);
      end

      // Back-to-back on the zero-wait instance: 4 writes then 4 reads, PREADY every second cycle
      foreach (d[i]) d[i] = $urandom;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         bus1.PSELx   = 1'b1;
         bus1.PENABLE = 1'b0;
         bus1.PWRITE  = (i < 4);
         bus1.PADDR   = AW'(4 * (i % 4));
         bus1.PWDATA  = (i < 4) ? d[i] : 32'h0;
         @(negedge clk);
         check($sformatf("b2b%0d_setup_pready", i), {31'd0, bus1.PREADY}, 32'd0);
         @(posedge clk); #1;
         bus1.PENABLE = 1'b1;
         @(negedge clk);
         check($sformatf("b2b%0d_pready", i), {31'd0, bus1.PREADY}, 32'd1);
         check($sformatf("b2b%0d_pslverr", i), {31'd0, bus1.PSLVERR}, 32'd0);
         if (i >= 4) check($sformatf("b2b%0d_prdata", i), bus1.PRDATA, d[i-4]);
      end
      @(posedge clk); #1;
      idle1();
      @(negedge clk);
      check("b2b_final_pready", {31'd0, bus1.PREADY}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
